sbox_layer_seq: RTL and testbench
=================================

Name: sbox_layer_seq

Overview:
- Sequential PRESENT substitution layer: applies the 4-bit PRESENT S-box to every nibble of a WIDTH-bit state word.
- Processes LANES nibbles per clock, trading area against latency.
- Sits between the round-key XOR and the permutation layer in the iterative round datapath.
- Uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 64: state width in bits; must be a multiple of 4*LANES (elaboration-time assertion).
- LANES, 4: S-box instances evaluated per cycle; range 1..WIDTH/4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word offered
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  state word to substitute
- out_valid  out  1  result held on out_data
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  substituted state word

Behaviour:
- Single clock; reset is asynchronous and active-high.
- NGROUPS = WIDTH/(4*LANES). Counter width = max(1, clog2(NGROUPS)).
- Reset values: state = IDLE, counter = 0, data register = 0, in_ready = 1, out_valid = 0, out_data = 0.
- FSM IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid, load in_data into the data register, clear the counter, go to BUSY.
- FSM BUSY:
  - in_ready = 0, out_valid = 0.
  - Each cycle, substitute the low LANES nibbles (nibble i = bits 4i+3:4i), then rotate the whole register right by 4*LANES bits.
  - Counter increments each cycle.
  - When counter == NGROUPS-1, go to DONE. After NGROUPS rotations every nibble is back in its original position.
- FSM DONE:
  - out_valid = 1, in_ready = 0.
  - out_data is driven directly from the data register and is stable while out_valid is high and out_ready is low.
  - On out_ready, go to IDLE.
- Latency and throughput:
  - The input handshake at edge 0 gives out_valid high after edge NGROUPS (4 cycles at the defaults).
  - Minimum initiation interval is NGROUPS+2 cycles.
- No overlap: in_valid asserted during BUSY or DONE is ignored (not accepted); the source holds it until in_ready.
- LANES = WIDTH/4 (NGROUPS = 1): BUSY lasts exactly one cycle.
- out_ready asserted outside DONE has no effect.
- Asynchronous reset in BUSY or DONE returns to IDLE immediately; the word in flight is discarded and out_valid drops without completing a handshake.
- S-box table (input:output, hex): 0:C 1:5 2:6 3:B 4:9 5:0 6:A 7:D 8:3 9:E A:F B:8 C:4 D:7 E:1 F:2.

Optional Feature:
- Macro: SBOX_LAYER_INV_EN.
- Defined:
  - Adds input port inv (1 bit), sampled together with in_data on the input handshake and held internally for the whole operation.
  - inv = 1 applies the inverse table (C:0 5:1 6:2 B:3 9:4 0:5 A:6 D:7 3:8 E:9 F:A 8:B 4:C 7:D 1:E 2:F) for decryption.
  - Changing inv after acceptance has no effect on the word in flight.
- Undefined: no inv port; forward table only; no extra area.

Decomposition:
- Shared package present_pkg holds:
  - The FSM state enumeration (IDLE, BUSY, DONE).
  - Constant PRESENT_NIBBLE_W = 4.
  - The forward and inverse S-box tables as 16-entry constant arrays.
- One natural sub-module: present_sbox_lut (4-bit in, 4-bit out, plus inv input when SBOX_LAYER_INV_EN is defined), instantiated LANES times in a generate loop.

Test Plan:
- Defaults, in_data = 64'h0123456789ABCDEF, out_ready = 1 → out_valid rises exactly 4 cycles after acceptance; out_data = 64'hC56B90AD3EF84712.
- in_data = 0, out_ready held low for 10 cycles → out_data = 64'hCCCCCCCCCCCCCCCC, stable, out_valid high throughout; in_ready = 0 with in_valid pulsed meanwhile; returns to IDLE on out_ready.
- LANES = 16 and LANES = 1, in_data = 64'h0123456789ABCDEF → same result; latency 1 and 16 cycles respectively.
- Assert rst during the second BUSY cycle → outputs return to reset values asynchronously; the next word 64'hFFFFFFFFFFFFFFFF yields 64'h2222222222222222.
- With SBOX_LAYER_INV_EN, inv = 1, in_data = 64'hC56B90AD3EF84712 → out_data = 64'h0123456789ABCDEF; toggling inv mid-BUSY leaves the result unchanged.
- Back-to-back: in_valid held high continuously → accepted words spaced NGROUPS+2 cycles apart; no word lost or duplicated over 20 random vectors checked against the reference table model.

Source files
------------

// File: rtl/sbox_layer_seq_pkg.sv
// present_pkg: shared types and constants for the PRESENT S-box layer.
//   state_t          : sequencer states (IDLE, BUSY, DONE)
//   PRESENT_NIBBLE_W : S-box input/output width
//   SBOX_FWD/INV     : forward and inverse PRESENT S-box tables, index = input
package present_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PRESENT_NIBBLE_W = 4;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

endpackage

// File: rtl/present_sbox_lut.sv
// present_sbox_lut: one 4-bit PRESENT S-box, pure combinational lookup.
//   din  : nibble in
//   inv  : select inverse table (only when SBOX_LAYER_INV_EN is defined)
//   dout : substituted nibble
module present_sbox_lut
  import present_pkg::*;
(
  input  logic [3:0] din,
`ifdef SBOX_LAYER_INV_EN
  input  logic       inv,
`endif
  output logic [3:0] dout
);

`ifdef SBOX_LAYER_INV_EN
  assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
`else
  assign dout = SBOX_FWD[din];
`endif

endmodule

// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: sequential PRESENT substitution layer. Applies the S-box to
// every nibble of a WIDTH-bit word, LANES nibbles per clock, by substituting
// the low LANES nibbles and rotating the register right each BUSY cycle.
// Optional macro SBOX_LAYER_INV_EN adds the 'inv' port (inverse S-box).
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : input handshake, in_data = word to substitute
//   inv                  : decrypt select, captured on acceptance (optional)
//   out_valid/out_ready  : output handshake, out_data = substituted word
module sbox_layer_seq
  import present_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef SBOX_LAYER_INV_EN
  input  logic             inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int LN      = (LANES < 1) ? 1 : LANES;
  localparam int LW      = PRESENT_NIBBLE_W * LN;
  localparam int NGROUPS = WIDTH / LW;
  localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  generate
    if ((LANES < 1) || (LANES > WIDTH / 4) || (WIDTH % LW != 0)) begin : g_bad_cfg
      $error("sbox_layer_seq: WIDTH must be a multiple of 4*LANES, 1 <= LANES <= WIDTH/4");
    end
  endgenerate

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] data;
  logic [LW-1:0]   sub_low;
  logic [WIDTH-1:0] subst, rot;
  logic            last;

`ifdef SBOX_LAYER_INV_EN
  logic            inv_q;
`endif

  assign last = (cnt == CW'(NGROUPS - 1));

  // S-box lanes always look at the bottom of the register; rotation brings
  // each group there in turn.
  generate
    for (genvar g = 0; g < LN; g++) begin : g_lane
      present_sbox_lut u_lut (
        .din  (data[g*4 +: 4]),
`ifdef SBOX_LAYER_INV_EN
        .inv  (inv_q),
`endif
        .dout (sub_low[g*4 +: 4])
      );
    end
  endgenerate

  always_comb begin
    subst         = data;
    subst[LW-1:0] = sub_low;
  end

  // Rotate right by one group; after NGROUPS rotations the word is aligned.
  generate
    if (NGROUPS == 1) begin : g_rot_none
      assign rot = subst;
    end else begin : g_rot
      assign rot = {subst[LW-1:0], subst[WIDTH-1:LW]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    out_data  = data;
  end

  // Datapath: load on acceptance, substitute+rotate while BUSY, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      cnt   <= '0;
`ifdef SBOX_LAYER_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data  <= in_data;
          cnt   <= '0;
`ifdef SBOX_LAYER_INV_EN
          inv_q <= inv;
`endif
        end
        BUSY: begin
          data <= rot;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Directed self-checking bench for sbox_layer_seq (default, LANES=16, LANES=1).
module tb_sbox_layer_seq;

  localparam logic [3:0] TF [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [63:0] in_data = '0, out_data;
  logic        inv = 1'b0;

  logic        vx = 1'b0, ordy_x = 1'b1;
  logic [63:0] dx = '0;
  logic        r16, ov16, r1, ov1;
  logic [63:0] d16, d1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sbox_layer_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SBOX_LAYER_INV_EN
    .inv(inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  sbox_layer_seq #(.WIDTH(64), .LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(vx), .in_ready(r16), .in_data(dx),
`ifdef SBOX_LAYER_INV_EN
    .inv(1'b0),
`endif
    .out_valid(ov16), .out_ready(ordy_x), .out_data(d16));

  sbox_layer_seq #(.WIDTH(64), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vx), .in_ready(r1), .in_data(dx),
`ifdef SBOX_LAYER_INV_EN
    .inv(1'b0),
`endif
    .out_valid(ov1), .out_ready(ordy_x), .out_data(d1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sref(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = TF[x[i*4 +: 4]];
    return r;
  endfunction

  // Offer one word to the main DUT; returns on the negedge after acceptance.
  task automatic send(input logic [63:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges after acceptance until out_valid; 40 means timed out.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, lat16, lat1, idx, got, cyc, last_acc;
    logic [63:0] vecs [20];
    logic [63:0] expq [$];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    rst = 1'b0;

    // Basic vector, out_ready held high
    out_ready = 1'b1;
    send(64'h0123456789ABCDEF);
    check("t1 busy in_ready", in_ready, 0);
    wait_out(lat);
    check("t1 latency", lat, 4);
    check("t1 data", out_data, 64'hC56B90AD3EF84712);
    @(negedge clk);
    check("t1 back idle out_valid", out_valid, 0);
    check("t1 back idle in_ready", in_ready, 1);

    // Zero word with output stall; in_valid pulses must be ignored
    out_ready = 1'b0;
    send(64'h0);
    wait_out(lat);
    check("t2 latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = {$urandom(), $urandom()};
      @(negedge clk);
      check("t2 stall out_valid", out_valid, 1);
      check("t2 stall data", out_data, 64'hCCCCCCCCCCCCCCCC);
      check("t2 stall in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t2 release out_valid", out_valid, 0);
    check("t2 release in_ready", in_ready, 1);
    check("t2 release data", out_data, 64'hCCCCCCCCCCCCCCCC);

    // LANES=16 and LANES=1 instances
    @(negedge clk);
    vx = 1'b1;
    dx = 64'h0123456789ABCDEF;
    @(negedge clk);
    vx = 1'b0;
    lat16 = -1;
    lat1  = -1;
    for (int t = 0; t <= 40; t++) begin
      if (ov16 && lat16 < 0) begin
        lat16 = t;
        check("l16 data", d16, 64'hC56B90AD3EF84712);
      end
      if (ov1 && lat1 < 0) begin
        lat1 = t;
        check("l1 data", d1, 64'hC56B90AD3EF84712);
      end
      if (lat16 >= 0 && lat1 >= 0) break;
      @(negedge clk);
    end
    check("l16 latency", lat16, 1);
    check("l1 latency", lat1, 16);
    @(negedge clk);
    check("l16 idle ready", r16, 1);
    check("l1 idle ready", r1, 1);

    // Asynchronous reset during the second BUSY cycle
    send(64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    check("t4 busy in_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("t4 async in_ready", in_ready, 1);
    check("t4 async out_valid", out_valid, 0);
    check("t4 async out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    send(64'hFFFFFFFFFFFFFFFF);
    wait_out(lat);
    check("t4 latency", lat, 4);
    check("t4 data", out_data, 64'h2222222222222222);
    @(negedge clk);

`ifdef SBOX_LAYER_INV_EN
    // Inverse table; inv toggled while BUSY must not matter
    @(negedge clk);
    in_valid = 1'b1;
    inv      = 1'b1;
    in_data  = 64'hC56B90AD3EF84712;
    @(negedge clk);
    in_valid = 1'b0;
    inv      = 1'b0;
    @(negedge clk);
    inv      = 1'b1;
    @(negedge clk);
    inv      = 1'b0;
    wait_out(lat);
    check("inv latency", lat, 4);
    check("inv data", out_data, 64'h0123456789ABCDEF);
    @(negedge clk);
`endif

    // Back-to-back with in_valid held high
    foreach (vecs[i]) vecs[i] = {$urandom(), $urandom()};
    idx = 0; got = 0; cyc = 0; last_acc = -1;
    for (int t = 0; t < 400 && got < 20; t++) begin
      if (out_valid) begin
        if (expq.size() == 0) check("b2b spurious out", 1, 0);
        else check("b2b data", out_data, expq.pop_front());
        got++;
      end
      if (idx < 20) begin
        in_valid = 1'b1;
        in_data  = vecs[idx];
        if (in_ready) begin
          expq.push_back(sref(vecs[idx]));
          if (last_acc >= 0) check("b2b spacing", cyc - last_acc, 6);
          last_acc = cyc;
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b outputs", got, 20);
    check("b2b accepted", idx, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
